// File: rtl/rnn_pkg.sv
// Shared constants for the denoise post-processing path: band layout,
// reciprocal table, Q-format widths and the small datapath helpers.
package rnn_pkg;

  localparam int NB_BANDS         = 22;
  localparam int FREQ_SIZE        = 481;
  localparam int FRAME_SIZE_SHIFT = 2;
  localparam int GAIN_W           = 16;
  localparam int DATA_W           = 16;
  localparam int GAIN_FRAC        = 15;
  localparam int FRAC_W           = 16;
  localparam int BIN_W            = 9;
  localparam int BAND_W           = 5;

  localparam logic [GAIN_W-1:0] GAIN_ONE = 16'd32768;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] EBAND5MS [NB_BANDS] = '{
    7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,  7'd8,  7'd10, 7'd12,
    7'd14, 7'd16, 7'd20, 7'd24, 7'd28, 7'd34, 7'd40, 7'd48, 7'd60, 7'd78, 7'd100
  };

  // floor(65536 / band size) for bands 0..NB_BANDS-2
  localparam logic [FRAC_W-1:0] RECIP [NB_BANDS-1] = '{
    16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384,
    16'd16384, 16'd8192,  16'd8192,  16'd8192,  16'd8192,  16'd4096,  16'd4096,
    16'd4096,  16'd2730,  16'd2730,  16'd2048,  16'd1365,  16'd910,   16'd744
  };

  function automatic logic [BIN_W-1:0] band_edge(input int b);
    return {2'b00, EBAND5MS[b]} << FRAME_SIZE_SHIFT;
  endfunction

  function automatic logic [BAND_W-1:0] band_of(input logic [BIN_W-1:0] bin);
    logic [BAND_W-1:0] b;
    b = '0;
    for (int i = 1; i < NB_BANDS; i++)
      if (bin >= band_edge(i)) b = BAND_W'(i);
    return b;
  endfunction

  // g_lo + floor((g_hi - g_lo) * frac / 65536); result stays within 0..GAIN_ONE
  function automatic logic [GAIN_W:0] interp_gain(input logic [GAIN_W-1:0] g_lo,
                                                  input logic [GAIN_W-1:0] g_hi,
                                                  input logic [FRAC_W-1:0] frac);
    logic signed [GAIN_W:0]              diff;
    logic signed [GAIN_W+FRAC_W+1:0]     prod;
    logic [GAIN_W+1:0]                   sum;
    diff = $signed({1'b0, g_hi}) - $signed({1'b0, g_lo});
    prod = $signed({{(FRAC_W+1){diff[GAIN_W]}}, diff}) * $signed({{(GAIN_W+2){1'b0}}, frac});
    sum  = {2'b00, g_lo} + prod[GAIN_W+FRAC_W+1:FRAC_W];
    return sum[GAIN_W:0];
  endfunction

  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [DATA_W-1:0] x,
                                                  input logic [GAIN_W:0] g);
    logic signed [DATA_W+GAIN_W+1:0] p;
    p = $signed({{(GAIN_W+2){x[DATA_W-1]}}, x}) * $signed({{(DATA_W+1){1'b0}}, g});
    p = p >>> GAIN_FRAC;
    if (!p[DATA_W+GAIN_W+1] && (|p[DATA_W+GAIN_W:DATA_W-1]))
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (p[DATA_W+GAIN_W+1] && !(&p[DATA_W+GAIN_W:DATA_W-1]))
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return p[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/gain_scale_pipe.sv
// Three-stage bin scaler: band lookup and fraction, gain interpolation,
// then saturating complex scale. All stages advance together on en.
module gain_scale_pipe
  import rnn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       out_ready,
  output logic                       en,
  input  logic                       in_fire,
  input  logic [BIN_W-1:0]           in_bin,
  input  logic [DATA_W-1:0]          in_re,
  input  logic [DATA_W-1:0]          in_im,
  input  logic                       in_last,
  input  logic [NB_BANDS*GAIN_W-1:0] gains,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_re,
  output logic [DATA_W-1:0]          out_im,
  output logic                       out_last
);

  logic [BAND_W-1:0] band_c;
  logic [BIN_W-1:0]  edge_c;
  logic [BIN_W-1:0]  j_c;
  logic [FRAC_W-1:0] recip_c;
  logic [FRAC_W-1:0] frac_c;
  logic              zero_c;

  logic              v1, zero1, last1;
  logic [BAND_W-1:0] band1;
  logic [FRAC_W-1:0] frac1;
  logic [DATA_W-1:0] re1, im1;

  logic              v2, last2;
  logic [GAIN_W:0]   g2;
  logic [DATA_W-1:0] re2, im2;

  logic [GAIN_W-1:0] g_lo, g_hi;

  assign en = !out_valid || out_ready;

  always_comb begin
    band_c  = band_of(in_bin);
    edge_c  = band_edge(int'(band_c));
    j_c     = in_bin - edge_c;
    zero_c  = (band_c == BAND_W'(NB_BANDS-1));
    recip_c = '0;
    for (int i = 0; i < NB_BANDS-1; i++)
      if (band_c == BAND_W'(i)) recip_c = RECIP[i];
    // product never exceeds 87*744, so the low 16 bits are exact
    frac_c  = FRAC_W'(j_c) * recip_c;
  end

  always_comb begin
    g_lo = '0;
    g_hi = '0;
    for (int i = 0; i < NB_BANDS-1; i++)
      if (band1 == BAND_W'(i)) begin
        g_lo = gains[i*GAIN_W +: GAIN_W];
        g_hi = gains[(i+1)*GAIN_W +: GAIN_W];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      band1     <= '0;
      frac1     <= '0;
      zero1     <= 1'b0;
      re1       <= '0;
      im1       <= '0;
      last1     <= 1'b0;
      v2        <= 1'b0;
      g2        <= '0;
      re2       <= '0;
      im2       <= '0;
      last2     <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      v1 <= in_fire;
      if (in_fire) begin
        band1 <= band_c;
        frac1 <= frac_c;
        zero1 <= zero_c;
        re1   <= in_re;
        im1   <= in_im;
        last1 <= in_last;
      end
      v2 <= v1;
      if (v1) begin
        g2    <= zero1 ? '0 : interp_gain(g_lo, g_hi, frac1);
        re2   <= re1;
        im2   <= im1;
        last2 <= last1;
      end
      out_valid <= v2;
      if (v2) begin
        out_re   <= scale_sat(re2, g2);
        out_im   <= scale_sat(im2, g2);
        out_last <= last2;
      end
    end
  end

endmodule

// File: rtl/band_gain_apply.sv
// Applies per-band gains, interpolated across FFT bins, to one spectrum frame.
// state    | meaning
// LOAD     | accept NB_BANDS gains, band 0 first
// RUN      | accept FREQ_SIZE bins into the scaling pipe
// DRAIN    | wait for the out_last transfer, then reload gains
module band_gain_apply #(
  parameter int NB_BANDS  = rnn_pkg::NB_BANDS,
  parameter int FREQ_SIZE = rnn_pkg::FREQ_SIZE,
  parameter int GAIN_W    = rnn_pkg::GAIN_W,
  parameter int DATA_W    = rnn_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gain_valid,
  output logic              gain_ready,
  input  logic [GAIN_W-1:0] gain_data,
  input  logic              bin_valid,
  output logic              bin_ready,
  input  logic [DATA_W-1:0] bin_re,
  input  logic [DATA_W-1:0] bin_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last
);

  localparam int GC_W = $clog2(NB_BANDS);
  localparam int BC_W = $clog2(FREQ_SIZE);

  rnn_pkg::state_t state, state_nx;

  logic [GC_W-1:0]            gain_cnt;
  logic [BC_W-1:0]            bin_cnt;
  logic [NB_BANDS*GAIN_W-1:0] gains;
  logic [GAIN_W-1:0]          gain_clamped;
  logic                       en, pipe_valid, pipe_last;
  logic                       gain_fire, bin_fire, out_fire;

  assign gain_fire    = gain_valid && gain_ready;
  assign bin_fire     = bin_valid && bin_ready;
  assign out_valid    = pipe_valid && rst_n;
  assign out_last     = pipe_last && out_valid;
  assign out_fire     = out_valid && out_ready;
  assign gain_clamped = (gain_data > rnn_pkg::GAIN_ONE) ? rnn_pkg::GAIN_ONE : gain_data;

  always_comb begin
    state_nx   = state;
    gain_ready = 1'b0;
    bin_ready  = 1'b0;
    case (state)
      rnn_pkg::ST_LOAD: begin
        gain_ready = rst_n;
        if (gain_fire && gain_cnt == GC_W'(NB_BANDS-1)) state_nx = rnn_pkg::ST_RUN;
      end
      rnn_pkg::ST_RUN: begin
        bin_ready = rst_n && en;
        if (bin_fire && bin_cnt == BC_W'(FREQ_SIZE-1)) state_nx = rnn_pkg::ST_DRAIN;
      end
      rnn_pkg::ST_DRAIN: begin
        if (out_fire && out_last) state_nx = rnn_pkg::ST_LOAD;
      end
      default: state_nx = rnn_pkg::ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= rnn_pkg::ST_LOAD;
      gain_cnt <= '0;
      bin_cnt  <= '0;
      gains    <= '0;
    end else begin
      state <= state_nx;
      if (gain_fire) begin
        gains[gain_cnt*GAIN_W +: GAIN_W] <= gain_clamped;
        gain_cnt <= (gain_cnt == GC_W'(NB_BANDS-1)) ? '0 : gain_cnt + 1'b1;
      end
      if (bin_fire)
        bin_cnt <= (bin_cnt == BC_W'(FREQ_SIZE-1)) ? '0 : bin_cnt + 1'b1;
    end
  end

  gain_scale_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_ready (out_ready),
    .en        (en),
    .in_fire   (bin_fire),
    .in_bin    (bin_cnt),
    .in_re     (bin_re),
    .in_im     (bin_im),
    .in_last   (bin_cnt == BC_W'(FREQ_SIZE-1)),
    .gains     (gains),
    .out_valid (pipe_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (pipe_last)
  );

endmodule

// File: tb/tb_band_gain_apply.sv
// Directed bench for band_gain_apply: reset, unity, interpolation, clamp,
// backpressure and mid-frame reset, with hand-computed expected outputs.
module tb_band_gain_apply;

  localparam int NB = 22;
  localparam int NF = 481;

  logic        clk;
  logic        rst_n;
  logic        gain_valid, gain_ready;
  logic [15:0] gain_data;
  logic        bin_valid, bin_ready;
  logic [15:0] bin_re, bin_im;
  logic        out_valid, out_ready;
  logic [15:0] out_re, out_im;
  logic        out_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_mode = 0;

  logic [15:0] gain_tab [NB];
  logic [15:0] re_tab [NF];
  logic [15:0] im_tab [NF];
  logic [15:0] got_re [512];
  logic [15:0] got_im [512];
  logic        got_last [512];
  int          got_cnt = 0;
  int          first_out_cyc = -1;
  int          first_bin_cyc = -1;

  logic        prev_stall = 1'b0;
  logic [15:0] prev_re = '0, prev_im = '0;

  band_gain_apply dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gain_valid (gain_valid),
    .gain_ready (gain_ready),
    .gain_data  (gain_data),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bin_re     (bin_re),
    .bin_im     (bin_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // output capture and stall-hold checks
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_re", 32'(out_re), 32'(prev_re));
          chk("hold_im", 32'(out_im), 32'(prev_im));
        end
        if (out_valid && !out_ready) chk("stall_bin_ready", 32'(bin_ready), 32'd0);
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (out_valid && out_ready) begin
          if (got_cnt < 512) begin
            got_re[got_cnt]   = out_re;
            got_im[got_cnt]   = out_im;
            got_last[got_cnt] = out_last;
          end
          got_cnt++;
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_re    = out_re;
      prev_im    = out_im;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_capture();
    got_cnt       = 0;
    first_out_cyc = -1;
    first_bin_cyc = -1;
  endtask

  task automatic load_gains();
    int   b = 0;
    int   budget = 2000;
    logic fire;
    gain_valid = 1'b1;
    gain_data  = gain_tab[0];
    while (b < NB && budget > 0) begin
      @(negedge clk);
      fire = gain_ready;
      @(posedge clk);
      #1;
      budget--;
      if (fire) begin
        b++;
        if (b < NB) gain_data = gain_tab[b];
      end
    end
    gain_valid = 1'b0;
    if (b < NB) chk("gain_load_done", b, NB);
  endtask

  task automatic send_bins(input int n);
    int   k = 0;
    int   budget = 5000;
    logic fire;
    bin_valid = 1'b1;
    bin_re    = re_tab[0];
    bin_im    = im_tab[0];
    while (k < n && budget > 0) begin
      @(negedge clk);
      fire = bin_ready;
      if (fire && first_bin_cyc < 0) first_bin_cyc = cyc;
      @(posedge clk);
      #1;
      budget--;
      if (fire) begin
        k++;
        if (k < NF) begin
          bin_re = re_tab[k];
          bin_im = im_tab[k];
        end
      end
    end
    bin_valid = 1'b0;
    if (k < n) chk("bins_sent", k, n);
  endtask

  task automatic wait_outputs(input int n);
    int budget = 4000;
    while (got_cnt < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  // kind 0: every bin (1000,-1000); kind 1: bin k is (k,-k); unity gains
  task automatic check_frame(input string name, input int kind);
    int errs = 0, lasts = 0, lastpos = -1;
    logic [15:0] er, ei;
    for (int i = 0; i < got_cnt && i < 512; i++) begin
      if (i < 400) begin
        er = (kind == 0) ? 16'd1000 : 16'(i);
        ei = (kind == 0) ? 16'hFC18 : 16'(-i);
      end else begin
        er = 16'd0;
        ei = 16'd0;
      end
      if (got_re[i] !== er || got_im[i] !== ei) errs++;
      if (got_last[i]) begin
        lasts++;
        lastpos = i;
      end
    end
    chk({name, "_count"}, got_cnt, NF);
    chk({name, "_data_errs"}, errs, 0);
    chk({name, "_last_count"}, lasts, 1);
    chk({name, "_last_pos"}, lastpos, NF-1);
    chk({name, "_back_to_load"}, 32'(gain_ready), 32'd1);
  endtask

  task automatic unity_setup(input int kind);
    for (int b = 0; b < NB; b++) gain_tab[b] = 16'd32768;
    for (int k = 0; k < NF; k++) begin
      re_tab[k] = (kind == 0) ? 16'd1000 : 16'(k);
      im_tab[k] = (kind == 0) ? 16'hFC18 : 16'(-k);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    gain_valid = 1'b0;
    gain_data  = '0;
    bin_valid  = 1'b1;
    bin_re     = 16'd1000;
    bin_im     = 16'hFC18;

    // reset held three cycles with bin_valid asserted
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_gain_ready", 32'(gain_ready), 32'd0);
    chk("rst_bin_ready", 32'(bin_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bin_valid = 1'b0;
    @(negedge clk);
    chk("rel_gain_ready", 32'(gain_ready), 32'd1);
    chk("rel_bin_ready", 32'(bin_ready), 32'd0);
    @(posedge clk);
    #1;

    // unity gains, constant bins
    unity_setup(0);
    clear_capture();
    load_gains();
    send_bins(NF);
    wait_outputs(NF);
    check_frame("unity", 0);
    chk("unity_latency", first_out_cyc - first_bin_cyc, 3);
    chk("unity_b399_re", 32'(got_re[399]), 32'd1000);
    chk("unity_b400_re", 32'(got_re[400]), 32'd0);

    // interpolation across band 0
    unity_setup(0);
    gain_tab[0] = 16'd0;
    for (int k = 0; k < 5; k++) begin
      re_tab[k] = 16'd32767;
      im_tab[k] = 16'd0;
    end
    clear_capture();
    load_gains();
    send_bins(NF);
    wait_outputs(NF);
    chk("interp_b0", 32'(got_re[0]), 32'd0);
    chk("interp_b1", 32'(got_re[1]), 32'd8191);
    chk("interp_b2", 32'(got_re[2]), 32'd16383);
    chk("interp_b3", 32'(got_re[3]), 32'd24575);
    chk("interp_b4", 32'(got_re[4]), 32'd32767);
    chk("interp_b1_im", 32'(got_im[1]), 32'd0);
    chk("interp_count", got_cnt, NF);

    // gain clamp on load
    unity_setup(0);
    gain_tab[0] = 16'd65535;
    re_tab[0]   = 16'h8000;
    im_tab[0]   = 16'h7FFF;
    clear_capture();
    load_gains();
    send_bins(NF);
    wait_outputs(NF);
    chk("clamp_b0_re", 32'(got_re[0]), 32'h8000);
    chk("clamp_b0_im", 32'(got_im[0]), 32'h7FFF);
    chk("clamp_b2_re", 32'(got_re[2]), 32'd1000);
    chk("clamp_count", got_cnt, NF);

    // backpressure: out_ready one cycle in three
    unity_setup(1);
    ready_mode = 1;
    clear_capture();
    load_gains();
    send_bins(NF);
    wait_outputs(NF);
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_frame("bp", 1);
    chk("bp_b250_re", 32'(got_re[250]), 32'd250);

    // reset while in RUN at bin 200
    unity_setup(0);
    clear_capture();
    load_gains();
    send_bins(200);
    rst_n = 1'b0;
    got_cnt = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bin_ready", 32'(bin_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_gain_ready", 32'(gain_ready), 32'd1);
    chk("midrst_out_valid_after", 32'(out_valid), 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_no_outputs", got_cnt, 0);
    @(posedge clk);
    #1;
    clear_capture();
    load_gains();
    send_bins(NF);
    wait_outputs(NF);
    check_frame("postrst", 0);
    chk("postrst_latency", first_out_cyc - first_bin_cyc, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
